memory_stage_lsu: RTL and testbench
===================================

MEMORY_STAGE_LSU -- requirements
Module: memory_stage_lsu

Interface
REQ-001 Parameter ADDR_W, default 64, shall set the address width.
REQ-002 Parameter DATA_W, default 64, shall set the data width; legal values are 32 and 64.
REQ-003 Parameter TAG_W, default 8, shall set the request tag width; the tag carries the opcode.
REQ-004 Parameter TIMEOUT, default 255, shall set the maximum number of cycles spent waiting for any handshake, in the range 1..65535.
REQ-005 Port clk, input, 1 bit, shall be the single clock; all state changes on its rising edge.
REQ-006 Port reset, input, 1 bit, shall be the reset: asynchronous, active-low.
REQ-007 Port in_valid, input, 1 bit, shall mean an instruction is present at the stage input.
REQ-008 Port wb_stall, input, 1 bit, shall mean writeback cannot accept a result.
REQ-009 Port is_load and port is_store, inputs, 1 bit each, shall give the access kind; an instruction with neither is a pass-through.
REQ-010 Port acc_size, input, 2 bits, shall give the access size: 0 is 1 byte, 1 is 2 bytes, 2 is 4 bytes, 3 is 8 bytes.
REQ-011 Port sign_ext, input, 1 bit, shall select sign extension (1) or zero extension (0) of load data.
REQ-012 Port addr, input, ADDR_W bits, shall give the access address; port st_data, input, DATA_W bits, shall give the store data.
REQ-013 Port tag_in, input, TAG_W bits, shall give the opcode tag.
REQ-014 Port out_valid, output, 1 bit, shall mean the result is complete this cycle; port ld_data, output, DATA_W bits, shall carry the extended load data.
REQ-015 Port stall, output, 1 bit, shall mean the stage holds the upstream pipeline.
REQ-016 Port err, output, 1 bit, shall be a sticky error flag.
REQ-017 Ports req_cyc, req_we, req_size (2 bits), req_addr, req_wdata and req_tag shall be outputs driving the dCache request channel; port req_ack shall be an input.
REQ-018 Ports resp_cyc and resp_data (DATA_W bits) shall be inputs; port resp_ack shall be an output.

Function
REQ-019 The FSM shall have four states: IDLE, REQ, WAIT, DONE.
REQ-020 IDLE to REQ shall occur when in_valid=1, (is_load or is_store)=1, wb_stall=0 and err=0; at that edge the block shall latch addr, st_data, acc_size, sign_ext and tag_in.
REQ-021 In IDLE with in_valid=1 and neither is_load nor is_store, the block shall assert out_valid combinationally with ld_data=0, zero cycles of latency, and stall=0.
REQ-022 In REQ the block shall hold req_cyc=1 with all request fields stable until the cycle req_ack=1; it shall then go to WAIT with req_cyc=0 from the next cycle.
REQ-023 In WAIT the block shall accept the first cycle with resp_cyc=1, register resp_data, pulse resp_ack for one cycle, and go to DONE.
REQ-024 Store responses shall complete the same way; their resp_data shall be discarded and ld_data driven as 0.
REQ-025 In DONE the block shall assert out_valid; if wb_stall=0 it shall return to IDLE next cycle, otherwise it shall hold DONE with ld_data stable.
REQ-026 Load data shall use the byte lane addr[2:0] for DATA_W=64 or addr[1:0] for DATA_W=32, shifted down to bit 0 and then sign- or zero-extended from 8, 16, 32 or 64 bits.
REQ-027 An access whose address is not a multiple of its size shall never issue a request; the block shall set err and go to DONE with ld_data=0.
REQ-028 acc_size=3 with DATA_W=32 shall be treated as misaligned under REQ-027.
REQ-029 stall shall be 1 in REQ, in WAIT, and in DONE while wb_stall=1; it shall be 1 in IDLE while a memory access is presented; it shall be 0 otherwise.
REQ-030 A timeout counter shall clear on each state entry and count in REQ and WAIT; on reaching TIMEOUT it shall set err, drop req_cyc and go to DONE with ld_data=0.
REQ-031 err shall clear only on reset; while err=1, memory accesses shall complete immediately as in REQ-027.
REQ-032 A resp_cyc that arrives in REQ or IDLE shall be ignored, and resp_ack shall not be asserted.

Reset
REQ-033 When reset=0 the state shall be IDLE, and req_cyc, req_we, resp_ack, out_valid, stall and err shall be 0; ld_data, req_addr, req_wdata, req_tag and the counter shall be 0.
REQ-034 Reset asserted mid-transaction shall abort the transaction immediately; a later stale resp_cyc shall be ignored per REQ-032.

Verification
REQ-035 Load, size 2, sign_ext=1, addr=0x1004, resp_data=0x80000000_00000000 -> ld_data=0xFFFFFFFF_80000000 and out_valid one cycle after resp_ack.
REQ-036 Store, size 1, addr=0x2002, st_data=0xBEEF -> req_we=1, req_size=1, req_wdata=0xBEEF; req_cyc is held for 3 cycles when req_ack is delayed by 3.
REQ-037 Load, size 3, addr=0x1003 -> no req_cyc, err=1, out_valid with ld_data=0.
REQ-038 TIMEOUT=4 and req_ack never arrives -> req_cyc drops after 4 cycles, err=1 and out_valid=1.
REQ-039 wb_stall=1 for 2 cycles in DONE -> out_valid and ld_data held, stall=1, then the return to IDLE.
REQ-040 reset=0 while in WAIT, followed by resp_cyc=1 -> state IDLE, resp_ack=0, all outputs at their reset values.

Source files
------------

// File: rtl/memory_stage_lsu_if.sv
// rtl/memory_stage_lsu_if.sv - dCache request/response channel between the memory stage and the cache
//
// Purpose: bundles the dCache request channel (req_*) and response channel (resp_*).
// Modports:
//   master - the memory stage: drives req_cyc/req_we/req_size/req_addr/req_wdata/req_tag
//            and resp_ack; receives req_ack, resp_cyc, resp_data.
//   slave  - the cache side: the mirror image of master.
interface memory_stage_lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64,
  parameter int TAG_W  = 8
);
  logic              req_cyc;
  logic              req_we;
  logic [1:0]        req_size;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [TAG_W-1:0]  req_tag;
  logic              req_ack;
  logic              resp_cyc;
  logic [DATA_W-1:0] resp_data;
  logic              resp_ack;

  modport master (
    output req_cyc, req_we, req_size, req_addr, req_wdata, req_tag, resp_ack,
    input  req_ack, resp_cyc, resp_data
  );

  modport slave (
    input  req_cyc, req_we, req_size, req_addr, req_wdata, req_tag, resp_ack,
    output req_ack, resp_cyc, resp_data
  );
endinterface

// File: rtl/memory_stage_lsu.sv
// rtl/memory_stage_lsu.sv - pipeline memory stage: load/store unit talking to the dCache
//
// Purpose: accepts one load/store at a time from the pipeline, issues it on the dCache
// channel, waits for the response, extracts and extends load data, and hands the result
// to writeback. Pass-through instructions complete combinationally in IDLE.
// Ports:
//   clk, reset          - clock; asynchronous active-low reset
//   in_valid, wb_stall  - instruction present / writeback cannot accept
//   is_load, is_store   - access kind (neither = pass-through)
//   acc_size, sign_ext  - access size (1/2/4/8 bytes), sign- vs zero-extend loads
//   addr, st_data, tag_in - access address, store data, opcode tag
//   out_valid, ld_data  - result complete / extended load data
//   stall, err          - hold upstream / sticky error
//   dc                  - dCache channel (master side)
module memory_stage_lsu #(
  parameter int ADDR_W  = 64,
  parameter int DATA_W  = 64,
  parameter int TAG_W   = 8,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  input  logic              wb_stall,
  input  logic              is_load,
  input  logic              is_store,
  input  logic [1:0]        acc_size,
  input  logic              sign_ext,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] st_data,
  input  logic [TAG_W-1:0]  tag_in,
  output logic              out_valid,
  output logic [DATA_W-1:0] ld_data,
  output logic              stall,
  output logic              err,
  memory_stage_lsu_if.master dc
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  localparam logic [15:0] TO_LAST   = 16'(TIMEOUT - 1);
  localparam logic [2:0]  LANE_MASK = (DATA_W == 64) ? 3'b111 : 3'b011;

  state_t            state_q, state_d;
  logic [15:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] ld_q;
  logic [TAG_W-1:0]  tag_q;
  logic [1:0]        size_q;
  logic              sext_q;
  logic              we_q;
  logic              err_q;

  logic              mem_op, accept, misalign, timeout_hit, resp_take, to_fire;
  logic [2:0]        lane;
  logic [63:0]       shifted, ext;

  assign mem_op      = is_load | is_store;
  assign accept      = (state_q == S_IDLE) & in_valid & mem_op & ~wb_stall;
  assign timeout_hit = (cnt_q == TO_LAST);
  assign resp_take   = (state_q == S_WAIT) & dc.resp_cyc;
  // A handshake arriving in the last allowed cycle wins over the timeout.
  assign to_fire     = timeout_hit & (((state_q == S_REQ) & ~dc.req_ack) |
                                      ((state_q == S_WAIT) & ~dc.resp_cyc));

  // 8-byte accesses cannot be carried on a 32-bit bus, so they count as misaligned.
  always_comb begin
    misalign = 1'b0;
    case (acc_size)
      2'd1:    misalign = addr[0];
      2'd2:    misalign = |addr[1:0];
      2'd3:    misalign = (|addr[2:0]) | (DATA_W == 32);
      default: misalign = 1'b0;
    endcase
  end

  // Load extraction works on a 64-bit view so both bus widths share one path.
  always_comb begin
    lane    = addr_q[2:0] & LANE_MASK;
    shifted = 64'(dc.resp_data) >> {lane, 3'b000};
    ext     = shifted;
    case (size_q)
      2'd0:    ext = {{56{sext_q & shifted[7]}},  shifted[7:0]};
      2'd1:    ext = {{48{sext_q & shifted[15]}}, shifted[15:0]};
      2'd2:    ext = {{32{sext_q & shifted[31]}}, shifted[31:0]};
      default: ext = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (accept) state_d = (misalign | err_q) ? S_DONE : S_REQ;
      S_REQ:   if (dc.req_ack) state_d = S_WAIT;
               else if (timeout_hit) state_d = S_DONE;
      S_WAIT:  if (dc.resp_cyc | timeout_hit) state_d = S_DONE;
      default: if (!wb_stall) state_d = S_IDLE;
    endcase
    cnt_d = '0;
    if (state_d == state_q && (state_q == S_REQ || state_q == S_WAIT))
      cnt_d = cnt_q + 16'd1;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      addr_q  <= '0;
      wdata_q <= '0;
      tag_q   <= '0;
      size_q  <= '0;
      sext_q  <= 1'b0;
      we_q    <= 1'b0;
      ld_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      if (accept) begin
        addr_q  <= addr;
        wdata_q <= st_data;
        tag_q   <= tag_in;
        size_q  <= acc_size;
        sext_q  <= sign_ext;
        we_q    <= is_store;
        ld_q    <= '0;
      end else if (resp_take) begin
        ld_q <= we_q ? '0 : ext[DATA_W-1:0];
      end
      if ((accept & misalign) | to_fire)
        err_q <= 1'b1;
    end
  end

  always_comb begin
    out_valid    = (state_q == S_DONE) | ((state_q == S_IDLE) & in_valid & ~mem_op);
    stall        = (state_q == S_REQ) | (state_q == S_WAIT) |
                   ((state_q == S_DONE) & wb_stall) |
                   ((state_q == S_IDLE) & in_valid & mem_op);
    ld_data      = (state_q == S_DONE) ? ld_q : '0;
    err          = err_q;
    dc.req_cyc   = (state_q == S_REQ);
    dc.req_we    = we_q;
    dc.req_size  = size_q;
    dc.req_addr  = addr_q;
    dc.req_wdata = wdata_q;
    dc.req_tag   = tag_q;
    dc.resp_ack  = resp_take;
  end

endmodule

// File: tb/tb_memory_stage_lsu.sv
// tb/tb_memory_stage_lsu.sv - scoreboard bench for memory_stage_lsu
module tb_memory_stage_lsu;
  logic        clk;
  logic        reset;
  logic        in_valid, wb_stall, is_load, is_store, sign_ext;
  logic [1:0]  acc_size;
  logic [63:0] addr, st_data;
  logic [7:0]  tag_in;
  logic        out_valid, stall, err;
  logic [63:0] ld_data;

  typedef struct {
    logic [63:0] ld;
    logic        er;
  } exp_t;

  exp_t sb_q[$];
  int   tests = 0;
  int   fails = 0;
  int   outs = 0;
  int   pushes = 0;

  memory_stage_lsu_if #(.ADDR_W(64), .DATA_W(64), .TAG_W(8)) dc ();

  memory_stage_lsu #(.ADDR_W(64), .DATA_W(64), .TAG_W(8), .TIMEOUT(4)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .wb_stall(wb_stall),
    .is_load(is_load), .is_store(is_store), .acc_size(acc_size), .sign_ext(sign_ext),
    .addr(addr), .st_data(st_data), .tag_in(tag_in), .out_valid(out_valid),
    .ld_data(ld_data), .stall(stall), .err(err), .dc(dc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [63:0] ld, input logic er);
    exp_t e;
    e.ld = ld;
    e.er = er;
    sb_q.push_back(e);
    pushes++;
  endtask

  // Monitor: compares every cycle out_valid is up; an entry retires when writeback accepts it.
  always @(negedge clk) begin
    if (reset && out_valid) begin
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL mon_unexpected: out_valid with ld_data %h, expected no output", ld_data);
      end else begin
        check("mon_ld_data", ld_data, sb_q[0].ld);
        check("mon_err", {63'b0, err}, {63'b0, sb_q[0].er});
        if (!wb_stall) begin
          sb_q.delete(0);
          outs++;
        end
      end
    end
  end

  task automatic check_reset_outputs(input string nm);
    check({nm, " req_cyc"}, dc.req_cyc, 0);
    check({nm, " req_we"}, dc.req_we, 0);
    check({nm, " resp_ack"}, dc.resp_ack, 0);
    check({nm, " out_valid"}, out_valid, 0);
    check({nm, " stall"}, stall, 0);
    check({nm, " err"}, err, 0);
    check({nm, " ld_data"}, ld_data, 0);
    check({nm, " req_addr"}, dc.req_addr, 0);
    check({nm, " req_wdata"}, dc.req_wdata, 0);
    check({nm, " req_tag"}, dc.req_tag, 0);
  endtask

  task automatic present(input logic st, input logic [1:0] sz, input logic sx,
                         input logic [63:0] a, input logic [63:0] wd, input logic [7:0] tg);
    in_valid = 1; is_load = !st; is_store = st; acc_size = sz; sign_ext = sx;
    addr = a; st_data = wd; tag_in = tg;
  endtask

  task automatic drop();
    in_valid = 0; is_load = 0; is_store = 0; addr = '0; st_data = '0; tag_in = '0;
    acc_size = 0; sign_ext = 0;
  endtask

  // Full transaction; starts and ends at posedge+1. Stale resp_cyc is driven during REQ.
  task automatic mem_op(input string nm, input logic st, input logic [1:0] sz, input logic sx,
                        input logic [63:0] a, input logic [63:0] wd, input logic [7:0] tg,
                        input int ack_dly, input logic [63:0] rd, input logic [63:0] exp_ld,
                        input int hold);
    int n;
    present(st, sz, sx, a, wd, tg);
    push(exp_ld, 1'b0);
    @(negedge clk);
    check({nm, " stall_idle"}, stall, 1);
    step();
    drop();
    n = 0;
    for (int i = 1; i <= ack_dly; i++) begin
      dc.resp_cyc = 1; dc.resp_data = 64'hDEAD_DEAD_DEAD_DEAD;
      dc.req_ack = (i == ack_dly);
      @(negedge clk);
      if (dc.req_cyc) n++;
      check({nm, " req_we"}, dc.req_we, st);
      check({nm, " req_size"}, dc.req_size, sz);
      check({nm, " req_addr"}, dc.req_addr, a);
      check({nm, " req_wdata"}, dc.req_wdata, wd);
      check({nm, " req_tag"}, dc.req_tag, tg);
      check({nm, " resp_ack_in_req"}, dc.resp_ack, 0);
      check({nm, " stall_req"}, stall, 1);
      step();
    end
    dc.req_ack = 0; dc.resp_cyc = 0;
    check({nm, " req_cyc_cycles"}, n, ack_dly);
    @(negedge clk);
    check({nm, " req_cyc_wait"}, dc.req_cyc, 0);
    check({nm, " stall_wait"}, stall, 1);
    dc.resp_cyc = 1; dc.resp_data = rd;
    #1;
    check({nm, " resp_ack"}, dc.resp_ack, 1);
    step();
    dc.resp_cyc = 0;
    wb_stall = (hold > 0);
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check({nm, " stall_done_held"}, stall, 1);
      check({nm, " out_valid_held"}, out_valid, 1);
      step();
    end
    wb_stall = 0;
    @(negedge clk);
    check({nm, " resp_ack_done"}, dc.resp_ack, 0);
    check({nm, " out_valid_done"}, out_valid, 1);
    check({nm, " stall_done"}, stall, 0);
    step();
    @(negedge clk);
    check({nm, " out_valid_idle"}, out_valid, 0);
    step();
  endtask

  // Access that must complete with err and no request.
  task automatic err_op(input string nm, input logic [1:0] sz, input logic [63:0] a);
    present(1'b0, sz, 1'b0, a, 64'h0, 8'h33);
    push(64'h0, 1'b1);
    @(negedge clk);
    check({nm, " stall_idle"}, stall, 1);
    step();
    drop();
    @(negedge clk);
    check({nm, " no_req_cyc"}, dc.req_cyc, 0);
    check({nm, " err"}, err, 1);
    check({nm, " out_valid"}, out_valid, 1);
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

  initial begin
    int  n;
    logic brk;
    reset = 0; wb_stall = 0; drop();
    dc.req_ack = 0; dc.resp_cyc = 0; dc.resp_data = '0;
    repeat (2) step();
    @(negedge clk);
    check_reset_outputs("reset");
    step();
    reset = 1;
    step();

    // Pass-through: combinational out_valid, no stall
    in_valid = 1;
    push(64'h0, 1'b0);
    @(negedge clk);
    check("pass out_valid", out_valid, 1);
    check("pass stall", stall, 0);
    step();
    drop();

    mem_op("ld_w_sx",  1'b0, 2'd2, 1'b1, 64'h1004, 64'h0, 8'h11, 1,
           64'h8000_0000_0000_0000, 64'hFFFF_FFFF_8000_0000, 0);
    mem_op("st_h",     1'b1, 2'd1, 1'b0, 64'h2002, 64'hBEEF, 8'h22, 3,
           64'h1111_2222_3333_4444, 64'h0, 0);
    mem_op("ld_b_zx",  1'b0, 2'd0, 1'b0, 64'h3005, 64'h0, 8'h13, 2,
           64'h0000_8A00_0000_0000, 64'h0000_0000_0000_008A, 0);
    mem_op("ld_b_sx",  1'b0, 2'd0, 1'b1, 64'h3005, 64'h0, 8'h14, 1,
           64'h0000_8A00_0000_0000, 64'hFFFF_FFFF_FFFF_FF8A, 0);
    mem_op("ld_h_sx",  1'b0, 2'd1, 1'b1, 64'h0006, 64'h0, 8'h15, 1,
           64'hC3A5_0000_0000_0000, 64'hFFFF_FFFF_FFFF_C3A5, 0);
    mem_op("ld_d_hold", 1'b0, 2'd3, 1'b0, 64'h0010, 64'h0, 8'h16, 2,
           64'h0123_4567_89AB_CDEF, 64'h0123_4567_89AB_CDEF, 2);

    err_op("misalign_d", 2'd3, 64'h1003);
    err_op("misalign_h", 2'd1, 64'h2001);
    err_op("sticky_err", 2'd2, 64'h1000);

    // Reset clears sticky err
    reset = 0;
    step();
    @(negedge clk);
    check("err_reset err", err, 0);
    step();
    reset = 1;
    step();

    // Timeout: req_ack never arrives
    present(1'b0, 2'd3, 1'b0, 64'h40, 64'h0, 8'h44);
    push(64'h0, 1'b1);
    step();
    drop();
    n = 0; brk = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (!dc.req_cyc) begin
        brk = 1;
        break;
      end
      n++;
      step();
    end
    check("timeout req_cyc_cycles", n, 4);
    if (!brk) @(negedge clk);
    check("timeout err", err, 1);
    check("timeout out_valid", out_valid, 1);
    step();

    // Reset during WAIT, then a stale response
    reset = 0;
    step();
    reset = 1;
    step();
    present(1'b0, 2'd3, 1'b0, 64'h80, 64'h0, 8'h5A);
    step();
    drop();
    dc.req_ack = 1;
    step();
    dc.req_ack = 0;
    @(negedge clk);
    check("abort in_wait stall", stall, 1);
    reset = 0;
    #1;
    check_reset_outputs("abort");
    step();
    reset = 1;
    dc.resp_cyc = 1; dc.resp_data = 64'hFFFF_0000_FFFF_0000;
    @(negedge clk);
    check("stale resp_ack", dc.resp_ack, 0);
    check("stale out_valid", out_valid, 0);
    check("stale stall", stall, 0);
    step();
    @(negedge clk);
    check("stale out_valid_later", out_valid, 0);
    dc.resp_cyc = 0;
    step();

    check("sb_empty", sb_q.size(), 0);
    check("outputs_seen", outs, pushes);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
